card_hand: RTL and testbench

Upstream dealing stage for the card display path. It runs a free-running 1..13 card counter and, on each deal request, latches the counter value into the next slot of a hand. It holds up to MAX_CARDS cards and keeps a registered baccarat score (card-value sum mod 10). Slot outputs use the 4-bit card encoding consumed by the per-digit seven-segment decoders: 1=A, 2..10, 11=J, 12=Q, 13=K, 0=empty/blank.

---
 rtl/card_hand.sv | 136 +++++++++++++
 tb/tb_card_hand.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/card_hand.sv
// Deals cards from a free-running 1..13 counter into a hand of up to MAX_CARDS slots.
// The card is stored one edge after the request is accepted. The score and deal_ack follow one edge later.
// Holding deal_req draws a single card; a request while the hand is full is ignored until deal_req is released.
module card_hand #(
    parameter int MAX_CARDS = 3
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   deal_req_i,
    input  logic                   clear_i,
    output logic [4*MAX_CARDS-1:0] cards_o,
    output logic [3:0]             last_card_o,
    output logic [2:0]             count_o,
    output logic                   full_o,
    output logic [3:0]             score_o,
    output logic                   deal_ack_o
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_CARDS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCORE    = 2'd1,
        ACK      = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             counter_q;
    logic [4*MAX_CARDS-1:0] cards_q, cards_d;
    logic [3:0]             last_card_q, last_card_d;
    logic [2:0]             count_q, count_d;
    logic [3:0]             score_q, score_d;
    logic                   deal_ack_q, deal_ack_d;
    logic [3:0]             card_val;
    logic [4:0]             sum;
    logic                   full;

    assign full = (count_q == MAX_CNT);

    // Free-running card counter 1..13. Clear and the FSM have no effect on it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            counter_q <= 4'd1;
        end else if (counter_q == 4'd13) begin
            counter_q <= 4'd1;
        end else begin
            counter_q <= counter_q + 4'd1;
        end
    end

    // Baccarat value of the most recent card: ten and the court cards score zero.
    always_comb begin
        card_val = 4'd0;
        if (last_card_q >= 4'd1 && last_card_q <= 4'd9) begin
            card_val = last_card_q;
        end
        sum = {1'b0, score_q} + {1'b0, card_val};
    end

    // Next-state and next-output logic. Clear overrides any in-flight draw.
    always_comb begin
        state_d     = state_q;
        cards_d     = cards_q;
        last_card_d = last_card_q;
        count_d     = count_q;
        score_d     = score_q;
        deal_ack_d  = 1'b0;

        if (clear_i) begin
            cards_d     = '0;
            last_card_d = 4'd0;
            count_d     = 3'd0;
            score_d     = 4'd0;
            state_d     = deal_req_i ? WAIT_REL : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (deal_req_i && !full) begin
                        for (int i = 0; i < MAX_CARDS; i++) begin
                            if (count_q == 3'(i)) begin
                                cards_d[4*i +: 4] = counter_q;
                            end
                        end
                        last_card_d = counter_q;
                        count_d     = count_q + 3'd1;
                        state_d     = SCORE;
                    end else if (deal_req_i) begin
                        state_d = WAIT_REL;
                    end
                end
                SCORE: begin
                    score_d    = (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
                    deal_ack_d = 1'b1;
                    state_d    = ACK;
                end
                ACK: begin
                    state_d = WAIT_REL;
                end
                WAIT_REL: begin
                    if (!deal_req_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers. Reset takes priority over everything.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cards_q     <= '0;
            last_card_q <= 4'd0;
            count_q     <= 3'd0;
            score_q     <= 4'd0;
            deal_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cards_q     <= cards_d;
            last_card_q <= last_card_d;
            count_q     <= count_d;
            score_q     <= score_d;
            deal_ack_q  <= deal_ack_d;
        end
    end

    assign cards_o     = cards_q;
    assign last_card_o = last_card_q;
    assign count_o     = count_q;
    assign full_o      = full;
    assign score_o     = score_q;
    assign deal_ack_o  = deal_ack_q;

endmodule

// File: tb/tb_card_hand.sv
// Directed bench for card_hand with MAX_CARDS=3.
// Inputs are driven and outputs sampled on the falling clock edge.
// A reference copy of the card counter is used to time the deal requests.
module tb_card_hand;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        deal_req_i = 1'b0;
    logic        clear_i = 1'b0;
    logic [11:0] cards_o;
    logic [3:0]  last_card_o;
    logic [2:0]  count_o;
    logic        full_o;
    logic [3:0]  score_o;
    logic        deal_ack_o;

    int   errs = 0;
    int   checks = 0;
    logic [3:0] cnt_m = 4'd1;

    card_hand #(.MAX_CARDS(3)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .deal_req_i  (deal_req_i),
        .clear_i     (clear_i),
        .cards_o     (cards_o),
        .last_card_o (last_card_o),
        .count_o     (count_o),
        .full_o      (full_o),
        .score_o     (score_o),
        .deal_ack_o  (deal_ack_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference card counter
    always @(posedge clk_i) begin
        if (reset_i) cnt_m <= 4'd1;
        else         cnt_m <= (cnt_m == 4'd13) ? 4'd1 : cnt_m + 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    // Wait (bounded) until the counter will present value v at the next rising edge.
    task automatic wait_cnt(input logic [3:0] v);
        int n = 0;
        while (cnt_m != v && n < 20) begin
            tick();
            n++;
        end
        chk("wait_cnt", {28'd0, cnt_m}, {28'd0, v});
    endtask

    // One-cycle request captured at counter value v. The hand is checked after E, E+1 and E+2.
    task automatic draw(input string tag, input logic [3:0] v, input logic [2:0] exp_cnt,
                        input logic [3:0] exp_score);
        wait_cnt(v);
        deal_req_i = 1'b1;
        tick();
        deal_req_i = 1'b0;
        chk({tag, "_last"}, last_card_o, v);
        chk({tag, "_count"}, count_o, exp_cnt);
        chk({tag, "_ack_E"}, deal_ack_o, 1'b0);
        tick();
        chk({tag, "_ack_E1"}, deal_ack_o, 1'b1);
        chk({tag, "_score"}, score_o, exp_score);
        tick();
        chk({tag, "_ack_E2"}, deal_ack_o, 1'b0);
        tick();
    endtask

    task automatic check_empty(input string tag);
        chk({tag, "_cards"}, cards_o, 12'h000);
        chk({tag, "_last"}, last_card_o, 4'd0);
        chk({tag, "_count"}, count_o, 3'd0);
        chk({tag, "_full"}, full_o, 1'b0);
        chk({tag, "_score"}, score_o, 4'd0);
        chk({tag, "_ack"}, deal_ack_o, 1'b0);
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    initial begin
        int acks;

        // Reset state
        repeat (3) tick();
        check_empty("rst");
        reset_i = 1'b0;

        // Single draw at 7
        draw("d7", 4'd7, 3'd1, 4'd7);
        chk("d7_cards", cards_o, 12'h007);
        chk("d7_full", full_o, 1'b0);

        // Fill the hand: 7, 5, 12 -> score 7, 2, 2
        draw("d5", 4'd5, 3'd2, 4'd2);
        draw("d12", 4'd12, 3'd3, 4'd2);
        chk("full_cards", cards_o, 12'hC57);
        chk("full_flag", full_o, 1'b1);

        // A request while full is ignored
        acks = 0;
        deal_req_i = 1'b1;
        repeat (6) begin
            tick();
            if (deal_ack_o) acks++;
        end
        deal_req_i = 1'b0;
        repeat (2) tick();
        chk("full_noack", acks, 0);
        chk("full_cards_kept", cards_o, 12'hC57);
        chk("full_count_kept", count_o, 3'd3);

        // Clear from idle
        do_clear();
        check_empty("clr");

        // Holding deal_req draws exactly one card
        acks = 0;
        wait_cnt(4'd3);
        deal_req_i = 1'b1;
        repeat (20) begin
            tick();
            if (deal_ack_o) acks++;
        end
        deal_req_i = 1'b0;
        repeat (2) tick();
        chk("hold_acks", acks, 1);
        chk("hold_count", count_o, 3'd1);
        chk("hold_last", last_card_o, 4'd3);
        chk("hold_score", score_o, 4'd3);

        // Counter wrap: 13 then 1
        do_clear();
        draw("d13", 4'd13, 3'd1, 4'd0);
        chk("d13_cards", cards_o, 12'h00D);
        do_clear();
        draw("d1", 4'd1, 3'd1, 4'd1);

        // Clear during SCORE with deal_req still high
        do_clear();
        wait_cnt(4'd6);
        deal_req_i = 1'b1;
        tick();
        chk("cs_pre_count", count_o, 3'd1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check_empty("cs");
        acks = 0;
        repeat (4) begin
            tick();
            if (deal_ack_o) acks++;
        end
        chk("cs_noack", acks, 0);
        chk("cs_wait_count", count_o, 3'd0);
        deal_req_i = 1'b0;
        tick();
        draw("cs_d9", 4'd9, 3'd1, 4'd9);

        // Reset during ACK
        wait_cnt(4'd4);
        deal_req_i = 1'b1;
        tick();
        deal_req_i = 1'b0;
        tick();
        chk("ra_ack_before", deal_ack_o, 1'b1);
        reset_i = 1'b1;
        tick();
        check_empty("ra");
        tick();
        reset_i = 1'b0;
        tick();
        deal_req_i = 1'b1;
        tick();
        deal_req_i = 1'b0;
        chk("ra_first_card", last_card_o, 4'd2);
        tick();
        chk("ra_ack", deal_ack_o, 1'b1);
        chk("ra_score", score_o, 4'd2);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
